multi_link_ctrl: RTL and testbench



---
 rtl/multi_link_pkg.sv | 41 ++++
 rtl/link_tx_arb.sv | 45 ++++
 rtl/multi_link_ctrl.sv | 144 ++++++++++++++
 tb/tb_multi_link_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_link_pkg.sv
// Shared byte codes, state encoding and pending-flag layout for the two-board link controller.
package multi_link_pkg;

  localparam logic [7:0] BYTE_READY = 8'hA5;
  localparam logic [7:0] BYTE_ACK   = 8'h5A;
  localparam logic [7:0] BYTE_ALIVE = 8'h3C;
  localparam logic [7:0] BYTE_LOST  = 8'hC3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ANNOUNCE = 2'd1,
    ST_PLAYING  = 2'd2,
    ST_DONE     = 2'd3
  } link_state_e;

  // Pending-flag bit positions; a higher index wins the transmitter first.
  localparam int PEND_ALIVE = 0;
  localparam int PEND_READY = 1;
  localparam int PEND_ACK   = 2;
  localparam int PEND_LOST  = 3;

  function automatic logic [3:0] pend_grant(input logic [3:0] pend);
    logic [3:0] g;
    g = 4'b0000;
    if (pend[PEND_LOST])       g[PEND_LOST]  = 1'b1;
    else if (pend[PEND_ACK])   g[PEND_ACK]   = 1'b1;
    else if (pend[PEND_READY]) g[PEND_READY] = 1'b1;
    else if (pend[PEND_ALIVE]) g[PEND_ALIVE] = 1'b1;
    return g;
  endfunction

  function automatic logic [7:0] grant_byte(input logic [3:0] grant);
    logic [7:0] b;
    b = BYTE_ALIVE;
    if (grant[PEND_LOST])       b = BYTE_LOST;
    else if (grant[PEND_ACK])   b = BYTE_ACK;
    else if (grant[PEND_READY]) b = BYTE_READY;
    return b;
  endfunction

endpackage

// File: rtl/link_tx_arb.sv
// Pending-byte flags and priority transmitter for the link controller (LOST > ACK > READY > ALIVE).
module link_tx_arb
  import multi_link_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_set,
  input  logic       i_drop,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_lost_pending
);

  logic [3:0] r_pend;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  logic [3:0] w_grant;
  logic       w_launch;

  // Handshake: a byte is launched only when tx_ready is high, something is pending and no strobe
  // went out on the previous cycle; tx_start is then high for exactly one cycle with tx_data valid.
  always_comb begin
    w_grant  = pend_grant(r_pend);
    w_launch = i_tx_ready && !r_tx_start && !i_drop && (r_pend != 4'b0000);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend     <= 4'b0000;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= w_launch;
      if (w_launch) r_tx_data <= grant_byte(w_grant);
      if (i_drop) r_pend <= 4'b0000;
      else        r_pend <= (r_pend & ~(w_launch ? w_grant : 4'b0000)) | i_set;
    end
  end

  assign o_tx_data      = r_tx_data;
  assign o_tx_start     = r_tx_start;
  assign o_lost_pending = r_pend[PEND_LOST];

endmodule

// File: rtl/multi_link_ctrl.sv
// Two-player link controller: READY/ACK handshake, heartbeats and loss reporting with the peer board.
// Optional silence timeout while playing is built when MULTI_LINK_TIMEOUT_EN is defined.
module multi_link_ctrl
  import multi_link_pkg::*;
#(
  parameter int RETRY_CYCLES     = 650000,
  parameter int HEARTBEAT_CYCLES = 3250000,
  parameter int TIMEOUT_CYCLES   = 65000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       player_ready,
  input  logic       multiplayer,
  input  logic       game_over,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       opponent_ready,
  output logic       opponent_lost,
  output logic       link_timeout,
  output logic [1:0] dbg_state
);

  localparam int CNT_MAX = (RETRY_CYCLES > HEARTBEAT_CYCLES) ? RETRY_CYCLES : HEARTBEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(HEARTBEAT_CYCLES - 1);

  link_state_e      r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_opp_ready, r_opp_lost, r_link_timeout;
  logic             w_rx_ready, w_rx_ack, w_rx_lost;
  logic             w_cnt_wrap, w_timeout, w_lost_pending;
  logic             w_drop, w_lost_pulse, w_timeout_hit;
  logic [3:0]       w_set;

  assign w_rx_ready = rx_valid && (rx_data == BYTE_READY);
  assign w_rx_ack   = rx_valid && (rx_data == BYTE_ACK);
  assign w_rx_lost  = rx_valid && (rx_data == BYTE_LOST);
  assign w_cnt_wrap = (r_state == ST_ANNOUNCE) ? (r_cnt == RETRY_LAST) : (r_cnt == HB_LAST);

`ifdef MULTI_LINK_TIMEOUT_EN
  localparam int SIL_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(TIMEOUT_CYCLES - 1);
  logic [SIL_W-1:0] r_silence;

  always_ff @(posedge clk) begin
    if (rst || rx_valid || (r_state != ST_PLAYING) || (w_next != r_state)) r_silence <= '0;
    else r_silence <= r_silence + 1'b1;
  end

  // A byte arriving on the limit cycle still counts as proof of life.
  assign w_timeout = (r_state == ST_PLAYING) && !rx_valid && (r_silence == SIL_LAST);
`else
  // No silence timer in this build; the parameter stays referenced but cannot fire.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_opp_ready    <= 1'b0;
      r_opp_lost     <= 1'b0;
      r_link_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_cnt_wrap || (r_state == ST_IDLE) || (r_state == ST_DONE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      r_opp_ready <= (w_next == ST_PLAYING);
      r_opp_lost  <= w_lost_pulse;
      if (w_timeout_hit)
        r_link_timeout <= 1'b1;
      else if ((r_state == ST_IDLE) && (w_next != ST_IDLE))
        r_link_timeout <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (player_ready) w_next = ST_ANNOUNCE;
      ST_ANNOUNCE: begin
        // Returning to the menu beats a byte that lands in the same cycle.
        if (!player_ready && !multiplayer) w_next = ST_IDLE;
        else if (w_rx_ready || w_rx_ack)   w_next = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (game_over || w_rx_lost || w_timeout) w_next = ST_DONE;
        else if (!multiplayer)                   w_next = ST_IDLE;
      end
      ST_DONE:     if (!w_lost_pending && !multiplayer) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_set         = 4'b0000;
    w_drop        = 1'b0;
    w_lost_pulse  = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: w_set[PEND_READY] = player_ready;
      ST_ANNOUNCE: begin
        if (w_next == ST_IDLE)         w_drop = 1'b1;
        else if (w_next == ST_PLAYING) w_set[PEND_ACK] = 1'b1;
        else                           w_set[PEND_READY] = w_cnt_wrap;
      end
      ST_PLAYING: begin
        if (game_over) w_set[PEND_LOST] = 1'b1;
        else if (w_rx_lost) w_lost_pulse = 1'b1;
        else if (w_timeout) begin
          w_lost_pulse  = 1'b1;
          w_timeout_hit = 1'b1;
        end else if (w_next == ST_PLAYING) begin
          w_set[PEND_ACK]   = w_rx_ready;
          w_set[PEND_ALIVE] = w_cnt_wrap;
        end
      end
      default: ;
    endcase
  end

  link_tx_arb u_tx_arb (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_set          (w_set),
    .i_drop         (w_drop),
    .i_tx_ready     (tx_ready),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .o_lost_pending (w_lost_pending)
  );

  assign opponent_ready = r_opp_ready;
  assign opponent_lost  = r_opp_lost;
  assign link_timeout   = r_link_timeout;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_multi_link_ctrl.sv
// Randomized scoreboard bench for multi_link_ctrl: expected tx bytes and their send cycles are queued
// from the link rules; a negedge monitor pops and compares every tx_start.
module tb_multi_link_ctrl;
  import multi_link_pkg::*;

  localparam int RETRY = 16;
  localparam int HB    = 32;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       rst, player_ready, multiplayer, game_over, rx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;
  logic       tx_start, opponent_ready, opponent_lost, link_timeout;
  logic [1:0] dbg_state;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         lost_seen = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  multi_link_ctrl #(
    .RETRY_CYCLES     (RETRY),
    .HEARTBEAT_CYCLES (HB),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .player_ready   (player_ready),
    .multiplayer    (multiplayer),
    .game_over      (game_over),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .opponent_ready (opponent_ready),
    .opponent_lost  (opponent_lost),
    .link_timeout   (link_timeout),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Present byte b so that it is sampled at edge e; returns at the negedge after edge e.
  task automatic rx_at(input int e, input logic [7:0] b);
    wait_until(e - 1);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b, input int c);
    exp_q.push_back(b);
    exp_cyc_q.push_back(c);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    logic [7:0] b;
    int         c;
    if (!rst && opponent_lost) lost_seen++;
    if (!rst && tx_start) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL tx_unexpected: byte %02h at cycle %0d, required no send", tx_data, cyc);
      end else begin
        b = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (tx_data === b && cyc == c) n_pass++;
        else $display("FAIL tx_byte: got %02h at cycle %0d, required %02h at cycle %0d",
                      tx_data, cyc, b, c);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0, ea, el, eg, er, ex, e1, k, m, h, hold;
    logic [7:0] junk;

    rst = 1'b1; player_ready = 1'b0; multiplayer = 1'b0; game_over = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) tick();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_opp_ready", opponent_ready, 0);
    check("rst_opp_lost", opponent_lost, 0);
    check("rst_link_timeout", link_timeout, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    repeat (2) tick();

    // A: retries, junk byte, peer READY, heartbeats, peer LOST
    e0 = cyc + 1;
    player_ready = 1'b1; multiplayer = 1'b1;
    k  = $urandom_range(1, 3);
    ea = e0 + RETRY * k + $urandom_range(4, 12);
    for (int j = 0; j <= k; j++) push_tx(BYTE_READY, e0 + RETRY * j + 1);
    do junk = 8'($urandom_range(0, 255));
    while (junk == BYTE_READY || junk == BYTE_ACK || junk == BYTE_ALIVE || junk == BYTE_LOST);
    rx_at(e0 + 2, junk);
    check("a_junk_state", dbg_state, ST_ANNOUNCE);
    wait_until(ea - 1);
    check("a_announce_opp_ready", opponent_ready, 0);
    rx_at(ea, BYTE_READY);
    check("a_opp_ready_set", opponent_ready, 1);
    check("a_state_playing", dbg_state, ST_PLAYING);
    push_tx(BYTE_ACK, ea + 1);
    m = $urandom_range(1, 2);
    for (int j = 1; j <= m; j++) push_tx(BYTE_ALIVE, ea + HB * j + 1);
    el = ea + HB * m + $urandom_range(4, 24);
    lost_seen = 0;
    rx_at(el, BYTE_LOST);
    check("a_opp_lost_pulse", opponent_lost, 1);
    check("a_opp_ready_clear", opponent_ready, 0);
    check("a_state_done", dbg_state, ST_DONE);
    tick();
    check("a_opp_lost_one_cycle", opponent_lost, 0);
    wait_until(el + 40);
    check("a_lost_pulse_count", lost_seen, 1);
    multiplayer = 1'b0; player_ready = 1'b0;
    repeat (2) tick();
    check("a_state_idle", dbg_state, ST_IDLE);
    check("a_queue_empty", exp_q.size(), 0);

    // B: peer ACK, repeated peer READY, local loss racing peer LOST
    tick();
    e0 = cyc + 1;
    player_ready = 1'b1; multiplayer = 1'b1;
    push_tx(BYTE_READY, e0 + 1);
    ea = e0 + $urandom_range(3, 12);
    push_tx(BYTE_ACK, ea + 1);
    rx_at(ea, BYTE_ACK);
    check("b_opp_ready_set", opponent_ready, 1);
    er = ea + $urandom_range(3, 10);
    push_tx(BYTE_ACK, er + 1);
    rx_at(er, BYTE_READY);
    eg = er + $urandom_range(3, 15);
    push_tx(BYTE_LOST, eg + 1);
    lost_seen = 0;
    wait_until(eg - 1);
    game_over = 1'b1; rx_valid = 1'b1; rx_data = BYTE_LOST;
    tick();
    rx_valid = 1'b0;
    check("b_opp_ready_clear", opponent_ready, 0);
    check("b_state_done", dbg_state, ST_DONE);
    repeat (5) tick();
    check("b_done_holds", dbg_state, ST_DONE);
    multiplayer = 1'b0; player_ready = 1'b0; game_over = 1'b0;
    repeat (2) tick();
    check("b_state_idle", dbg_state, ST_IDLE);
    check("b_no_opp_lost", lost_seen, 0);
    check("b_queue_empty", exp_q.size(), 0);

    // C: menu exit racing peer READY while the READY byte is still pending
    tx_ready = 1'b0;
    tick();
    e0 = cyc + 1;
    player_ready = 1'b1; multiplayer = 1'b1;
    ex = e0 + $urandom_range(3, 12);
    wait_until(ex - 1);
    player_ready = 1'b0; multiplayer = 1'b0; rx_valid = 1'b1; rx_data = BYTE_READY;
    tick();
    rx_valid = 1'b0;
    check("c_state_idle", dbg_state, ST_IDLE);
    check("c_opp_ready", opponent_ready, 0);
    tx_ready = 1'b1;
    repeat (20) tick();
    check("c_opp_ready_later", opponent_ready, 0);
    check("c_queue_empty", exp_q.size(), 0);

    // D: transmitter busy across retries merges READYs; leave via multiplayer=0
    tx_ready = 1'b0;
    tick();
    e0 = cyc + 1;
    player_ready = 1'b1; multiplayer = 1'b1;
    h    = $urandom_range(1, 2);
    hold = RETRY * h + $urandom_range(4, 10);
    push_tx(BYTE_READY, e0 + hold + 1);
    push_tx(BYTE_READY, e0 + RETRY * (h + 1) + 1);
    ea = e0 + RETRY * (h + 1) + 6;
    push_tx(BYTE_ACK, ea + 1);
    wait_until(e0 + hold);
    tx_ready = 1'b1;
    rx_at(ea, BYTE_READY);
    ex = ea + $urandom_range(3, 20);
    wait_until(ex - 1);
    multiplayer = 1'b0; player_ready = 1'b0;
    tick();
    check("d_state_idle", dbg_state, ST_IDLE);
    check("d_opp_ready_clear", opponent_ready, 0);
    repeat (3) tick();
    check("d_queue_empty", exp_q.size(), 0);

    // E: silence while playing
    tick();
    e0 = cyc + 1;
    player_ready = 1'b1; multiplayer = 1'b1;
    push_tx(BYTE_READY, e0 + 1);
    ea = e0 + $urandom_range(3, 12);
    push_tx(BYTE_ACK, ea + 1);
    push_tx(BYTE_ALIVE, ea + HB + 1);
    lost_seen = 0;
    rx_at(ea, BYTE_READY);
`ifdef MULTI_LINK_TIMEOUT_EN
    wait_until(ea + TO - 1);
    check("e_before_timeout_state", dbg_state, ST_PLAYING);
    check("e_before_timeout_flag", link_timeout, 0);
    tick();
    check("e_timeout_flag", link_timeout, 1);
    check("e_timeout_opp_lost", opponent_lost, 1);
    check("e_timeout_state", dbg_state, ST_DONE);
    tick();
    check("e_timeout_pulse_one", opponent_lost, 0);
    multiplayer = 1'b0; player_ready = 1'b0;
    repeat (2) tick();
    check("e_idle_keeps_timeout", link_timeout, 1);
    e1 = cyc + 1;
    player_ready = 1'b1; multiplayer = 1'b1;
    push_tx(BYTE_READY, e1 + 1);
    tick();
    check("e_timeout_cleared", link_timeout, 0);
    wait_until(e1 + 4);
    player_ready = 1'b0; multiplayer = 1'b0;
    repeat (2) tick();
    check("e_lost_pulse_count", lost_seen, 1);
`else
    push_tx(BYTE_ALIVE, ea + 2 * HB + 1);
    push_tx(BYTE_ALIVE, ea + 3 * HB + 1);
    wait_until(ea + 100);
    check("e_no_timeout_state", dbg_state, ST_PLAYING);
    check("e_no_timeout_flag", link_timeout, 0);
    check("e_no_timeout_opp_ready", opponent_ready, 1);
    check("e_no_opp_lost", lost_seen, 0);
    multiplayer = 1'b0; player_ready = 1'b0;
    repeat (2) tick();
    e1 = cyc;
`endif
    check("e_state_idle", dbg_state, ST_IDLE);
    check("e_queue_empty", exp_q.size(), 0);

    // F: reset in mid-handshake with READY still pending
    tx_ready = 1'b0;
    player_ready = 1'b1; multiplayer = 1'b1;
    repeat ($urandom_range(2, 8)) tick();
    rst = 1'b1; player_ready = 1'b0; multiplayer = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    check("f_state_idle", dbg_state, ST_IDLE);
    repeat (10) tick();
    check("f_no_tx_after_reset", exp_q.size(), 0);
    check("f_opp_ready", opponent_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
